hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 37 +++
 rtl/hazard_forward_unit_compare.sv | 22 ++
 rtl/hazard_forward_unit.sv | 174 +++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding unit: operand-mux select encodings
// and the shadow-pipeline stage records.
package hazard_forward_unit_pkg;

  // Record address fields are sized for the widest register file this unit
  // is expected to serve. Narrower indices are zero-extended on entry, so
  // REG_ADDR_W in the top must not exceed this value.
  localparam int REC_ADDR_W = 6;

  // EXE operand-mux select encodings. 2'b11 is never driven.
  typedef enum logic [1:0] {
    SEL_ID  = 2'b00,  // register-file value read in ID
    SEL_WB  = 2'b01,  // result currently in WB
    SEL_MEM = 2'b10   // result currently in MEM
  } sel_t;

  // What every shadow stage tracks about the instruction it holds.
  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_read;
    logic [REC_ADDR_W-1:0] dest;
  } stage_rec_t;

  // EXE also keeps the source indices so the forwarding selects can be
  // computed from registered state only.
  typedef struct packed {
    stage_rec_t            base;
    logic [REC_ADDR_W-1:0] src1;
    logic [REC_ADDR_W-1:0] src2;
    logic                  use_src2;
  } exe_rec_t;

  localparam stage_rec_t STAGE_REC_EMPTY = '0;
  localparam exe_rec_t   EXE_REC_EMPTY   = '0;

endpackage

// File: rtl/hazard_forward_unit_compare.sv
// hazard_compare: does a stage record produce the register a source reads?
// A hit needs a live instruction that writes back, a source that is
// actually read, and equal indices. need_load further restricts the hit to
// loads, which is how the load-use check reuses the same comparator.
module hazard_compare
  import hazard_forward_unit_pkg::*;
(
  input  stage_rec_t            rec,
  input  logic [REC_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  logic                  need_load,
  output logic                  match
);

  logic producer_ok;
  logic idx_eq;

  assign producer_ok = rec.valid & rec.wb_en & (~need_load | rec.mem_read);
  assign idx_eq      = (rec.dest == src);
  assign match       = producer_ok & src_used & idx_eq;

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: shadow EXE/MEM/WB pipeline that drives the EXE
// operand-mux selects and the RAW-hazard stall for the instruction in ID.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  forward_en,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src2,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dest,
  output logic                  stall,
  output logic [1:0]            sel_src1,
  output logic [1:0]            sel_src2
);

  // Zero-extend an ID register index to record width.
  function automatic logic [REC_ADDR_W-1:0] widen_idx(input logic [REG_ADDR_W-1:0] idx);
    return REC_ADDR_W'(idx);
  endfunction

  // MEM has priority over WB because it holds the younger write.
  function automatic sel_t pick_sel(input logic en, input logic mem_hit, input logic wb_hit);
    sel_t s;
    s = SEL_ID;
    if (en) begin
      if (mem_hit)     s = SEL_MEM;
      else if (wb_hit) s = SEL_WB;
    end
    return s;
  endfunction

  exe_rec_t   id_rec;
  exe_rec_t   exe_rec_d, exe_rec_q;
  stage_rec_t mem_rec_d, mem_rec_q;
  stage_rec_t wb_rec_d,  wb_rec_q;

  logic [REC_ADDR_W-1:0] id_src1_w;
  logic [REC_ADDR_W-1:0] id_src2_w;

  logic mem_hit_exe1, mem_hit_exe2;
  logic wb_hit_exe1,  wb_hit_exe2;
  logic exe_hit_id1,  exe_hit_id2;
  logic mem_hit_id1,  mem_hit_id2;
  logic src2_used_id;
  logic stall_w;

  assign id_src1_w    = widen_idx(id_src1);
  assign id_src2_w    = widen_idx(id_src2);
  assign src2_used_id = id_valid & id_use_src2;

  // Package the ID-stage instruction as an EXE record.
  always_comb begin
    id_rec               = EXE_REC_EMPTY;
    id_rec.base.valid    = id_valid;
    id_rec.base.wb_en    = id_wb_en;
    id_rec.base.mem_read = id_mem_read;
    id_rec.base.dest     = widen_idx(id_dest);
    id_rec.src1          = id_src1_w;
    id_rec.src2          = id_src2_w;
    id_rec.use_src2      = id_use_src2;
  end

  // ---- ID -> EXE boundary: stall checks against the instruction in ID ----
  // With forwarding on, only a load in EXE blocks (its data is not ready
  // until MEM); with forwarding off, any producer in EXE blocks.
  hazard_compare u_cmp_exe_id1 (
    .rec       (exe_rec_q.base),
    .src       (id_src1_w),
    .src_used  (id_valid),
    .need_load (forward_en),
    .match     (exe_hit_id1)
  );

  hazard_compare u_cmp_exe_id2 (
    .rec       (exe_rec_q.base),
    .src       (id_src2_w),
    .src_used  (src2_used_id),
    .need_load (forward_en),
    .match     (exe_hit_id2)
  );

  // Producers in MEM only matter when there is no forwarding path; WB is
  // covered by the write-first register file.
  hazard_compare u_cmp_mem_id1 (
    .rec       (mem_rec_q),
    .src       (id_src1_w),
    .src_used  (id_valid),
    .need_load (1'b0),
    .match     (mem_hit_id1)
  );

  hazard_compare u_cmp_mem_id2 (
    .rec       (mem_rec_q),
    .src       (id_src2_w),
    .src_used  (src2_used_id),
    .need_load (1'b0),
    .match     (mem_hit_id2)
  );

  assign stall_w = exe_hit_id1 | exe_hit_id2 |
                   (~forward_en & (mem_hit_id1 | mem_hit_id2));
  assign stall   = stall_w;

  // ---- EXE operand selects: registered EXE sources vs MEM/WB producers ----
  hazard_compare u_cmp_mem_exe1 (
    .rec       (mem_rec_q),
    .src       (exe_rec_q.src1),
    .src_used  (1'b1),
    .need_load (1'b0),
    .match     (mem_hit_exe1)
  );

  hazard_compare u_cmp_mem_exe2 (
    .rec       (mem_rec_q),
    .src       (exe_rec_q.src2),
    .src_used  (exe_rec_q.use_src2),
    .need_load (1'b0),
    .match     (mem_hit_exe2)
  );

  hazard_compare u_cmp_wb_exe1 (
    .rec       (wb_rec_q),
    .src       (exe_rec_q.src1),
    .src_used  (1'b1),
    .need_load (1'b0),
    .match     (wb_hit_exe1)
  );

  hazard_compare u_cmp_wb_exe2 (
    .rec       (wb_rec_q),
    .src       (exe_rec_q.src2),
    .src_used  (exe_rec_q.use_src2),
    .need_load (1'b0),
    .match     (wb_hit_exe2)
  );

  // An invalid EXE record cannot hit (its producers are gated by the
  // records' own valid bits, and a bubble's sources are never consumed).
  assign sel_src1 = pick_sel(forward_en & exe_rec_q.base.valid, mem_hit_exe1, wb_hit_exe1);
  assign sel_src2 = pick_sel(forward_en & exe_rec_q.base.valid, mem_hit_exe2, wb_hit_exe2);

  // Next shadow state: shift EXE->MEM->WB; EXE takes ID or a bubble when
  // the ID instruction is held back or squashed.
  always_comb begin
    exe_rec_d = id_rec;
    if (stall_w || flush) begin
      exe_rec_d = EXE_REC_EMPTY;
    end
    mem_rec_d = exe_rec_q.base;
    wb_rec_d  = mem_rec_q;
  end

  // ---- EXE/MEM/WB pipeline registers; reset discards everything in flight ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_rec_q <= EXE_REC_EMPTY;
      mem_rec_q <= STAGE_REC_EMPTY;
      wb_rec_q  <= STAGE_REC_EMPTY;
    end else begin
      exe_rec_q <= exe_rec_d;
      mem_rec_q <= mem_rec_d;
      wb_rec_q  <= wb_rec_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: short instruction sequences with
// hand-computed stall and operand-select values.
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst;
  logic       forward_en;
  logic       flush;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_use_src2;
  logic       id_wb_en;
  logic       id_mem_read;
  logic [3:0] id_dest;
  logic       stall;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;

  int n_chk;
  int n_err;

  hazard_forward_unit #(.REG_ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .forward_en  (forward_en),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src2 (id_use_src2),
    .id_wb_en    (id_wb_en),
    .id_mem_read (id_mem_read),
    .id_dest     (id_dest),
    .stall       (stall),
    .sel_src1    (sel_src1),
    .sel_src2    (sel_src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Settle combinational outputs, then check stall and both selects.
  task automatic expect3(input string tag, input logic st, input logic [1:0] s1, input logic [1:0] s2);
    #1;
    chk({tag, "_stall"}, {3'b0, stall}, {3'b0, st});
    chk({tag, "_sel1"}, {2'b0, sel_src1}, {2'b0, s1});
    chk({tag, "_sel2"}, {2'b0, sel_src2}, {2'b0, s2});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic u2, input logic w, input logic mr, input logic [3:0] d);
    id_valid    = v;
    id_src1     = s1;
    id_src2     = s2;
    id_use_src2 = u2;
    id_wb_en    = w;
    id_mem_read = mr;
    id_dest     = d;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic drain(input int n);
    nop();
    repeat (n) tick();
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b0;
    forward_en = 1'b1;
    flush      = 1'b0;
    // A valid load to r0 sits in ID during reset: nothing may stall.
    set_id(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    tick();
    expect3("rst_hold", 1'b0, 2'b00, 2'b00);
    rst = 1'b1;
    drain(3);
    expect3("rst_idle", 1'b0, 2'b00, 2'b00);

    // ADD r1,r2,r3 ; ADD r2,r1,r3 -> src1 from MEM
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
    expect3("fwmem_c0", 1'b0, 2'b00, 2'b00);
    tick();
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
    expect3("fwmem_c1", 1'b0, 2'b00, 2'b00);
    tick();
    nop();
    expect3("fwmem_c2", 1'b0, 2'b10, 2'b00);
    forward_en = 1'b0;
    expect3("fwoff_sel", 1'b0, 2'b00, 2'b00);
    forward_en = 1'b1;
    drain(3);

    // ADD r1 ; NOP ; SUB r4,r5,r1 -> src2 from WB
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    nop();
    tick();
    set_id(1'b1, 4'd5, 4'd1, 1'b1, 1'b1, 1'b0, 4'd4);
    expect3("fwwb_c2", 1'b0, 2'b00, 2'b00);
    tick();
    nop();
    expect3("fwwb_c3", 1'b0, 2'b00, 2'b01);
    drain(3);

    // LDR r1,[r6] ; ADD r2,r1,r1 -> one stall cycle, then both from WB
    set_id(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1);
    expect3("ldu_c0", 1'b0, 2'b00, 2'b00);
    tick();
    set_id(1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd2);
    expect3("ldu_c1", 1'b1, 2'b00, 2'b00);
    tick();
    expect3("ldu_c2", 1'b0, 2'b00, 2'b00);
    tick();
    nop();
    expect3("ldu_c3", 1'b0, 2'b01, 2'b01);
    drain(3);

    // forwarding off: ADD r1 ; ADD r2,r1,r3 -> two stall cycles
    forward_en = 1'b0;
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
    expect3("nofw_c1", 1'b1, 2'b00, 2'b00);
    tick();
    expect3("nofw_c2", 1'b1, 2'b00, 2'b00);
    tick();
    expect3("nofw_c3", 1'b0, 2'b00, 2'b00);
    tick();
    nop();
    expect3("nofw_c4", 1'b0, 2'b00, 2'b00);
    drain(3);
    forward_en = 1'b1;

    // ADD r1 ; ADD r1 ; ADD r7,r1,r8 -> MEM wins over WB
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    set_id(1'b1, 4'd4, 4'd5, 1'b1, 1'b1, 1'b0, 4'd1);
    expect3("prio_c1", 1'b0, 2'b00, 2'b00);
    tick();
    set_id(1'b1, 4'd1, 4'd8, 1'b1, 1'b1, 1'b0, 4'd7);
    expect3("prio_c2", 1'b0, 2'b00, 2'b00);
    tick();
    nop();
    expect3("prio_c3", 1'b0, 2'b10, 2'b00);
    drain(3);

    // ADD r9 ; ADD r1 ; ADD r7,r1,r9 -> src1 from MEM, src2 from WB
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd9);
    tick();
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    set_id(1'b1, 4'd1, 4'd9, 1'b1, 1'b1, 1'b0, 4'd7);
    tick();
    nop();
    expect3("indep", 1'b0, 2'b10, 2'b01);
    drain(3);

    // CMP-like op to r1 with wb_en=0 -> nothing forwarded
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 4'd1);
    tick();
    set_id(1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd2);
    expect3("nowb_c1", 1'b0, 2'b00, 2'b00);
    tick();
    nop();
    expect3("nowb_c2", 1'b0, 2'b00, 2'b00);
    drain(3);

    // ADD r3 ; LDR r1,[r3] ; ADD r2,r1,r3 then reset mid-flight
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd3);
    tick();
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1);
    tick();
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
    expect3("rst_pre", 1'b1, 2'b10, 2'b00);
    rst = 1'b0;
    tick();
    expect3("rst_c1", 1'b0, 2'b00, 2'b00);
    rst = 1'b1;
    tick();
    nop();
    expect3("rst_c2", 1'b0, 2'b00, 2'b00);
    drain(3);

    // ADD r1 ; ADD r2,r1,r3 squashed by flush -> no forward afterwards
    set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nop();
    expect3("flush_c1", 1'b0, 2'b00, 2'b00);
    drain(3);

    // LDR r1 ; dependent squashed by flush while load-use pending
    set_id(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1);
    tick();
    set_id(1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nop();
    expect3("flushld_c1", 1'b0, 2'b00, 2'b00);
    tick();
    expect3("flushld_c2", 1'b0, 2'b00, 2'b00);
    drain(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
